vector_op_queue: RTL and testbench

- Issue buffer placed directly upstream of the vector coprocessor top.
- Accepts operations (op, lmul, sew) from the host/scalar core on a valid/ready handshake and holds them in a small FIFO.
- Presents the head entry to the coprocessor's vsi_op/vsi_op_valid/vsi_op_ready port, so the host does not stall while the coprocessor is busy.
- Reports combined system idle and the queue occupancy, and supports a synchronous flush.

---
 rtl/vector_cop_pkg.sv | 9 +
 rtl/vector_op_queue_if.sv | 27 ++
 rtl/vop_fifo_core.sv | 50 +++++
 rtl/vector_op_queue.sv | 55 +++++
 tb/tb_vector_op_queue.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vector_cop_pkg.sv
// vector_cop_pkg: shared vector op word type and width, used by the op queue and the control unit
package vector_cop_pkg;
  localparam int VSI_OP_W = 34;
  typedef struct packed {
    logic [31:0] op;
    logic        lmul;
    logic        sew;
  } vsi_op_t;
endpackage

// File: rtl/vector_op_queue_if.sv
// vector_op_queue_if: host push side, coprocessor issue side, flush and status; slave = queue, master = host/cop
interface vector_op_queue_if #(parameter int DEPTH = 4);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] host_op;
  logic        host_lmul;
  logic        host_sew;
  logic        host_valid;
  logic        host_ready;
  logic        flush;
  logic [31:0] vsi_op;
  logic        vsi_lmul;
  logic        vsi_sew;
  logic        vsi_op_valid;
  logic        vsi_op_ready;
  logic        vsi_cop_idle;
  logic        sys_idle;
  logic [AW:0] q_count;
  logic [15:0] issued_cnt;
  modport slave (
    input  host_op, host_lmul, host_sew, host_valid, flush, vsi_op_ready, vsi_cop_idle,
    output host_ready, vsi_op, vsi_lmul, vsi_sew, vsi_op_valid, sys_idle, q_count, issued_cnt
  );
  modport master (
    output host_op, host_lmul, host_sew, host_valid, flush, vsi_op_ready, vsi_cop_idle,
    input  host_ready, vsi_op, vsi_lmul, vsi_sew, vsi_op_valid, sys_idle, q_count, issued_cnt
  );
endinterface

// File: rtl/vop_fifo_core.sv
// vop_fifo_core: W-bit x DEPTH fifo; push/pop/flush in, full/empty/count/head (zero when empty) out
module vop_fifo_core #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  always_comb begin
    full     = count_q == CW'(DEPTH);
    empty    = count_q == '0;
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = flush ? '0 : do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = flush ? '0 :
               (do_push & ~do_pop) ? count_q + CW'(1) :
               (do_pop & ~do_push) ? count_q - CW'(1) : count_q;
    count    = count_q;
    head     = empty ? '0 : mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/vector_op_queue.sv
// vector_op_queue: issue fifo between host and coprocessor; vsi_clk/vsi_rst_n plus bus (slave) carrying handshakes and status
module vector_op_queue
  import vector_cop_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                vsi_clk,
  input  logic                vsi_rst_n,
  vector_op_queue_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  logic          en_q, en_d;
  logic [15:0]   issued_q, issued_d;
  logic          host_ready, op_valid, push, pop, full, empty;
  logic [AW:0]   count;
  vsi_op_t       din, head;
  always_comb begin
    din            = '{op: bus.host_op, lmul: bus.host_lmul, sew: bus.host_sew};
    host_ready     = en_q & ~full & ~bus.flush;
    op_valid       = ~empty & ~bus.flush;
    push           = bus.host_valid & host_ready;
    pop            = op_valid & bus.vsi_op_ready;
    issued_d       = pop ? issued_q + 16'd1 : issued_q;
    en_d           = 1'b1;
    bus.host_ready   = host_ready;
    bus.vsi_op_valid = op_valid;
    bus.vsi_op       = head.op;
    bus.vsi_lmul     = head.lmul;
    bus.vsi_sew      = head.sew;
    bus.sys_idle     = en_q & empty & bus.vsi_cop_idle;
    bus.q_count      = count;
    bus.issued_cnt   = issued_q;
  end
  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      en_q     <= 1'b0;
      issued_q <= '0;
    end else begin
      en_q     <= en_d;
      issued_q <= issued_d;
    end
  end
  vop_fifo_core #(.W(VSI_OP_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (vsi_clk),
    .rst_n (vsi_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   (din),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_vector_op_queue.sv
// tb_vector_op_queue: table, directed and random checks of vector_op_queue against a queue model
module tb_vector_op_queue;
  localparam int DEPTH = 4;
  logic vsi_clk = 1'b0;
  logic vsi_rst_n;
  always #5 vsi_clk = ~vsi_clk;
  vector_op_queue_if #(.DEPTH(DEPTH)) bus ();
  vector_op_queue #(.DEPTH(DEPTH)) dut (.vsi_clk(vsi_clk), .vsi_rst_n(vsi_rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [33:0] head_w;
  assign head_w = {bus.vsi_op, bus.vsi_lmul, bus.vsi_sew};
  typedef struct {
    logic        hv;
    logic [31:0] op;
    logic        lmul;
    logic        sew;
    logic        rdy;
    logic        idle;
    logic        e_ready;
    logic        e_valid;
    logic [33:0] e_head;
    logic [2:0]  e_cnt;
    logic        e_idle;
    logic [15:0] e_iss;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge vsi_clk);
    #1;
  endtask
  task automatic drive(input logic hv, input logic [31:0] op, input logic rdy, input logic fl);
    bus.host_valid   = hv;
    bus.host_op      = op;
    bus.host_lmul    = 1'b0;
    bus.host_sew     = 1'b0;
    bus.vsi_op_ready = rdy;
    bus.flush        = fl;
  endtask
  task automatic do_reset;
    vsi_rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    bus.vsi_cop_idle = 1'b1;
    repeat (2) @(posedge vsi_clk);
    @(negedge vsi_clk);
    vsi_rst_n = 1'b1;
  endtask
  logic [33:0] mq[$];
  logic [15:0] iss_m;
  logic        en_m, hv, rdy, fl, l, s, er, ev;
  logic [31:0] op;
  logic [33:0] eh;
  initial begin
    tbl[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 34'h0,              3'd0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 32'h0000_5457, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 34'h0,              3'd0, 1'b1, 16'd0};
    for (int i = 2; i < 7; i++)
      tbl[i] = '{1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {32'h0000_5457, 2'b10}, 3'd1, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {32'h0000_5457, 2'b10}, 3'd1, 1'b0, 16'd0};
    tbl[8] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 34'h0,              3'd0, 1'b1, 16'd1};
    tbl[9] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0,              3'd0, 1'b0, 16'd1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].hv, tbl[i].op, tbl[i].rdy, 1'b0);
      bus.host_lmul    = tbl[i].lmul;
      bus.host_sew     = tbl[i].sew;
      bus.vsi_cop_idle = tbl[i].idle;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(bus.host_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.vsi_op_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_head", i), 64'(head_w), 64'(tbl[i].e_head));
      chk($sformatf("tbl%0d_count", i), 64'(bus.q_count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_sys_idle", i), 64'(bus.sys_idle), 64'(tbl[i].e_idle));
      chk($sformatf("tbl%0d_issued", i), 64'(bus.issued_cnt), 64'(tbl[i].e_iss));
      tick();
    end
    bus.vsi_cop_idle = 1'b1;
    // fill and backpressure: ops 1..5 with the coprocessor stalled
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      #1;
      chk("fill_ready", 64'(bus.host_ready), 64'd1);
      tick();
    end
    drive(1'b1, 32'd5, 1'b0, 1'b0);
    #1;
    chk("full_ready", 64'(bus.host_ready), 64'd0);
    chk("full_count", 64'(bus.q_count), 64'd4);
    chk("full_head", 64'(bus.vsi_op), 64'd1);
    tick();
    chk("stall_ready", 64'(bus.host_ready), 64'd0);
    bus.vsi_op_ready = 1'b1;
    #1;
    chk("full_pop_ready", 64'(bus.host_ready), 64'd0);
    chk("full_pop_valid", 64'(bus.vsi_op_valid), 64'd1);
    tick();
    bus.vsi_op_ready = 1'b0;
    #1;
    chk("freed_ready", 64'(bus.host_ready), 64'd1);
    chk("freed_count", 64'(bus.q_count), 64'd3);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      #1;
      chk("drain_order", 64'(bus.vsi_op), 64'(k));
      tick();
    end
    chk("drain_count", 64'(bus.q_count), 64'd0);
    chk("drain_issued", 64'(bus.issued_cnt), 64'd6);
    // full-rate stream of 20 ops
    drive(1'b1, 32'd100, 1'b1, 1'b0);
    #1;
    chk("stream_first_valid", 64'(bus.vsi_op_valid), 64'd0);
    tick();
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, 32'(100 + i), 1'b1, 1'b0);
      #1;
      chk("stream_valid", 64'(bus.vsi_op_valid), 64'd1);
      chk("stream_op", 64'(bus.vsi_op), 64'(100 + i - 1));
      chk("stream_count", 64'(bus.q_count), 64'd1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("stream_last", 64'(bus.vsi_op), 64'd119);
    tick();
    chk("stream_empty", 64'(bus.q_count), 64'd0);
    chk("stream_issued", 64'(bus.issued_cnt), 64'd26);
    // flush with three queued ops and a host offer pending
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(i * 17), 1'b0, 1'b0);
      tick();
    end
    chk("preflush_count", 64'(bus.q_count), 64'd3);
    drive(1'b1, 32'h99, 1'b1, 1'b1);
    #1;
    chk("flush_ready", 64'(bus.host_ready), 64'd0);
    chk("flush_valid", 64'(bus.vsi_op_valid), 64'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("postflush_count", 64'(bus.q_count), 64'd0);
    chk("postflush_valid", 64'(bus.vsi_op_valid), 64'd0);
    chk("postflush_issued", 64'(bus.issued_cnt), 64'd26);
    drive(1'b1, 32'hAA, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("afterflush_op", 64'(bus.vsi_op), 64'hAA);
    tick();
    chk("afterflush_issued", 64'(bus.issued_cnt), 64'd27);
    // asynchronous reset with two queued ops
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, 32'(i + 40), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    vsi_rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.host_ready), 64'd0);
    chk("arst_valid", 64'(bus.vsi_op_valid), 64'd0);
    chk("arst_head", 64'(head_w), 64'd0);
    chk("arst_count", 64'(bus.q_count), 64'd0);
    chk("arst_sys_idle", 64'(bus.sys_idle), 64'd0);
    chk("arst_issued", 64'(bus.issued_cnt), 64'd0);
    @(negedge vsi_clk);
    vsi_rst_n = 1'b1;
    tick();
    chk("arst_rel_count", 64'(bus.q_count), 64'd0);
    chk("arst_rel_issued", 64'(bus.issued_cnt), 64'd0);
    chk("arst_rel_ready", 64'(bus.host_ready), 64'd1);
    // randomized traffic against a queue model
    do_reset();
    mq.delete();
    iss_m = '0;
    en_m  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      hv  = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 1) == 1;
      fl  = $urandom_range(0, 15) == 0;
      l   = $urandom_range(0, 1) == 1;
      s   = $urandom_range(0, 1) == 1;
      op  = $urandom;
      drive(hv, op, rdy, fl);
      bus.host_lmul    = l;
      bus.host_sew     = s;
      bus.vsi_cop_idle = $urandom_range(0, 1) == 1;
      #1;
      er = en_m && mq.size() < DEPTH && !fl;
      ev = mq.size() > 0 && !fl;
      eh = mq.size() > 0 ? mq[0] : 34'h0;
      chk("rnd_ready", 64'(bus.host_ready), 64'(er));
      chk("rnd_valid", 64'(bus.vsi_op_valid), 64'(ev));
      chk("rnd_head", 64'(head_w), 64'(eh));
      chk("rnd_count", 64'(bus.q_count), 64'(mq.size()));
      chk("rnd_sys_idle", 64'(bus.sys_idle), 64'(en_m && mq.size() == 0 && bus.vsi_cop_idle));
      chk("rnd_issued", 64'(bus.issued_cnt), 64'(iss_m));
      if (fl) mq.delete();
      else begin
        if (ev && rdy) begin
          void'(mq.pop_front());
          iss_m++;
        end
        if (hv && er) mq.push_back({op, l, s});
      end
      en_m = 1'b1;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
